diagv2_ecall_handler: RTL and testbench

Synthesizable system-call responder for the diag-v2 RV64 core, servicing the ECALL the core raises at the end of the pipeline. It freezes the core, then services the call: EXIT (a7=93) latches the exit code and halts; WRITE (a7=64) streams a buffer from data memory out a byte-wide valid/ready port and returns the byte count in a0. Any other call number is flagged as an error and returns -ENOSYS. It sits beside the core and dmem in diagv2_top and replaces bench-side ECALL handling in hardware builds.

---
 rtl/diagv2_ecall_handler.sv | 155 +++++++++++++++
 tb/tb_diagv2_ecall_handler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diagv2_ecall_handler.sv
// diag-v2 ECALL responder: freezes the core, then services EXIT and WRITE
// system calls in hardware, returning results through the x10 write port.
module diagv2_ecall_handler #(
    parameter int DATA_W  = 64,
    parameter int MAX_LEN = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ecall,
    input  logic [DATA_W-1:0] a7,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    output logic              stall,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              ret_we,
    output logic [DATA_W-1:0] ret_data,
    output logic              halt,
    output logic [DATA_W-1:0] exit_code,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        SEND,
        RET,
        HALTED
    } state_t;

    localparam logic [DATA_W-1:0] SYS_EXIT  = DATA_W'(93);
    localparam logic [DATA_W-1:0] SYS_WRITE = DATA_W'(64);
    localparam logic [DATA_W-1:0] FD_OUT    = DATA_W'(1);
    localparam logic [DATA_W-1:0] FD_ERR    = DATA_W'(2);
    localparam logic [DATA_W-1:0] LEN_MAX   = DATA_W'(MAX_LEN);
    // two's complement of ENOSYS (38) and EBADF (9)
    localparam logic [DATA_W-1:0] RET_NOSYS = ~DATA_W'(37);
    localparam logic [DATA_W-1:0] RET_BADF  = ~DATA_W'(8);

    state_t            state;
    logic              holdoff;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] idx;

    logic              dispatch;
    logic              is_exit;
    logic              is_write;
    logic              fd_ok;
    logic              len_zero;
    logic [DATA_W-1:0] len_cap;
    logic [DATA_W-1:0] idx_nxt;

    assign dispatch = (state == IDLE) && ecall && !holdoff;
    assign is_exit  = (a7 == SYS_EXIT);
    assign is_write = (a7 == SYS_WRITE);
    assign fd_ok    = (a0 == FD_OUT) || (a0 == FD_ERR);
    assign len_zero = (a2 == '0);
    assign len_cap  = (a2 > LEN_MAX) ? LEN_MAX : a2;
    assign idx_nxt  = idx + DATA_W'(1);

    // combinational so the core freezes in the cycle ecall first appears
    assign stall = (state != IDLE) || dispatch;
    assign err   = dispatch && !is_exit && !is_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            holdoff   <= 1'b0;
            base_q    <= '0;
            cnt       <= '0;
            idx       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            ret_we    <= 1'b0;
            ret_data  <= '0;
            halt      <= 1'b0;
            exit_code <= '0;
        end else begin
            mem_req <= 1'b0;
            ret_we  <= 1'b0;
            unique case (state)
                IDLE: begin
                    holdoff <= 1'b0;
                    if (dispatch) begin
                        base_q <= a1;
                        idx    <= '0;
                        if (is_exit) begin
                            exit_code <= a0;
                            halt      <= 1'b1;
                            state     <= HALTED;
                        end else if (is_write && fd_ok && !len_zero) begin
                            cnt      <= len_cap;
                            mem_addr <= a1;
                            mem_req  <= 1'b1;
                            state    <= RD;
                        end else begin
                            if (!is_write)
                                ret_data <= RET_NOSYS;
                            else if (len_zero)
                                ret_data <= '0;
                            else
                                ret_data <= RET_BADF;
                            ret_we <= 1'b1;
                            state  <= RET;
                        end
                    end
                end
                RD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    tx_data  <= mem_rdata;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        idx      <= idx_nxt;
                        if (idx_nxt == cnt) begin
                            ret_data <= cnt;
                            ret_we   <= 1'b1;
                            state    <= RET;
                        end else begin
                            mem_addr <= base_q + idx_nxt;
                            mem_req  <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                RET: begin
                    // keep the retiring ECALL from being serviced again
                    holdoff <= 1'b1;
                    state   <= IDLE;
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diagv2_ecall_handler.sv
// Scoreboard bench for diagv2_ecall_handler: directed syscall scenarios
// followed by randomized calls against a behavioural syscall model.
module tb_diagv2_ecall_handler;

    localparam int DW = 64;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ecall = 1'b0;
    logic [DW-1:0] a7 = '0;
    logic [DW-1:0] a0 = '0;
    logic [DW-1:0] a1 = '0;
    logic [DW-1:0] a2 = '0;
    logic          stall;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic [7:0]    mem_rdata = '0;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic          ret_we;
    logic [DW-1:0] ret_data;
    logic          halt;
    logic [DW-1:0] exit_code;
    logic          err;

    diagv2_ecall_handler #(.DATA_W(DW), .MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset), .ecall(ecall),
        .a7(a7), .a0(a0), .a1(a1), .a2(a2),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .ret_we(ret_we), .ret_data(ret_data),
        .halt(halt), .exit_code(exit_code), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // data memory: 256-byte image aliased across the address space
    logic [7:0] mem [256];
    always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr[7:0]];

    int checks = 0;
    int failures = 0;

    logic [7:0]    q_tx[$];
    logic [DW-1:0] q_addr[$];
    logic [DW-1:0] q_ret[$];

    function automatic void chk(string name, logic [DW-1:0] act,
                                logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // tx_ready pattern: 0 always, 1 random, 2 low in cycles 6..9, 3 low from 9
    int tr_mode = 0;
    int base = 0;
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            1: tx_ready = ($urandom_range(0, 3) != 0);
            2: tx_ready = !((cyc - base) >= 6 && (cyc - base) <= 9);
            3: tx_ready = ((cyc - base) < 9);
            default: tx_ready = 1'b1;
        endcase
    end

    logic [7:0] held;
    bit         hold_v = 0;
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, held);
            end
            hold_v = tx_valid && !tx_ready;
            held = tx_data;
            if (tx_valid && tx_ready) begin
                chk("tx_expected", q_tx.size() > 0, 1);
                if (q_tx.size() > 0) chk("tx_data", tx_data, q_tx.pop_front());
            end
            if (mem_req) begin
                chk("rd_expected", q_addr.size() > 0, 1);
                if (q_addr.size() > 0) chk("mem_addr", mem_addr, q_addr.pop_front());
            end
            if (ret_we) begin
                chk("ret_expected", q_ret.size() > 0, 1);
                if (q_ret.size() > 0) chk("ret_data", ret_data, q_ret.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        ecall = 1'b0;
        tr_mode = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        q_tx.delete();
        q_addr.delete();
        q_ret.delete();
    endtask

    // Issue one ECALL, push the model's response, wait for completion.
    task automatic do_call(input logic [DW-1:0] s7, input logic [DW-1:0] f0,
                           input logic [DW-1:0] b1, input logic [DW-1:0] l2,
                           input int mode, input bit chk_lat);
        bit            ex = 0;
        bit            e = 0;
        int            n = 0;
        int            t = 0;
        int            elat;
        logic [DW-1:0] r = '0;
        logic [DW-1:0] ad;
        if (s7 == 93) begin
            ex = 1;
        end else if (s7 == 64) begin
            if ((f0 == 1 || f0 == 2) && l2 != 0) begin
                n = (l2 > ML) ? ML : int'(l2);
                r = DW'(n);
                for (int k = 0; k < n; k++) begin
                    ad = b1 + DW'(k);
                    q_addr.push_back(ad);
                    q_tx.push_back(mem[ad[7:0]]);
                end
            end else if (l2 == 0) begin
                r = '0;
            end else begin
                r = -64'sd9;
            end
        end else begin
            e = 1;
            r = -64'sd38;
        end
        if (!ex) q_ret.push_back(r);
        elat = (n > 0) ? 1 + 3 * n + ((mode == 2) ? 4 : 0) : 1;

        @(posedge clk); #1;
        ecall = 1'b1;
        a7 = s7; a0 = f0; a1 = b1; a2 = l2;
        base = cyc;
        tr_mode = mode;
        @(negedge clk);
        chk("stall_c0", stall, 1);
        chk("err_c0", err, e);
        while (!(ret_we || halt) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("no_timeout", t < 3000, 1);
        if (chk_lat) chk("latency", t, elat);
        if (ex) begin
            chk("halt", halt, 1);
            chk("exit_code", exit_code, f0);
            chk("exit_no_ret", ret_we, 0);
        end
        if (t >= 3000) begin
            do_reset();
        end else begin
            @(negedge clk);
            chk(ex ? "stall_halted" : "stall_release", stall, ex);
            @(posedge clk); #1;
            ecall = 1'b0;
            tr_mode = 0;
            a7 = {$urandom, $urandom};
            repeat (2) @(negedge clk);
        end
        chk("tx_left", q_tx.size(), 0);
        chk("ret_left", q_ret.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] s7, f0, b1, l2;
        int            md;
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] s7, f0, b1, l2;
        int            md;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h48; mem[1] = 8'h69; mem[2] = 8'h0A;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_ret_we", ret_we, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("rst_halt", halt, 0);
        chk("rst_exit_code", exit_code, 0);
        chk("rst_err", err, 0);

        // EXIT is absorbing: a later WRITE must produce nothing
        do_call(93, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        ecall = 1'b1; a7 = 64; a0 = 1; a1 = 64'h100; a2 = 3;
        repeat (6) begin
            @(negedge clk);
            chk("halted_stall", stall, 1);
            chk("halted_no_req", mem_req, 0);
            chk("halted_no_tx", tx_valid, 0);
        end
        do_reset();
        @(negedge clk);
        chk("halt_cleared", halt, 0);

        do_call(64, 1, 64'h100, 3, 0, 1);
        do_call(64, 2, 64'h100, 3, 2, 1);
        do_call(64, 5, 64'h100, 3, 0, 1);
        do_call(57, 1, 64'h100, 3, 0, 1);
        do_call(64, 1, 64'h100, 0, 0, 1);
        do_call(64, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        do_call(64, 1, 64'h37, 64'h8000_0000_0000_0000, 0, 1);

        // reset while byte 2 sits in SEND with tx_ready low
        q_addr.push_back(64'h40); q_addr.push_back(64'h41);
        q_addr.push_back(64'h42);
        q_tx.push_back(mem[8'h40]); q_tx.push_back(mem[8'h41]);
        @(posedge clk); #1;
        ecall = 1'b1; a7 = 64; a0 = 1; a1 = 64'h40; a2 = 4;
        base = cyc;
        tr_mode = 3;
        for (int w = 0; w < 50 && (cyc - base) < 9; w++) @(posedge clk);
        #1 reset = 1'b1;
        ecall = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", tx_valid, 1);
        chk("pre_rst_q_tx", q_tx.size(), 0);
        chk("pre_rst_q_addr", q_addr.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tr_mode = 0;
        @(negedge clk);
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_ret_data", ret_data, 0);
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        do_call(64, 9, 0, 1, 0, 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                5: s7 = 57;
                6: begin
                    s7 = {$urandom, $urandom};
                    if (s7 == 93) s7 = 94;
                end
                default: s7 = 64;
            endcase
            case ($urandom_range(0, 5))
                0: f0 = 0;
                1, 2: f0 = 1;
                3: f0 = 2;
                4: f0 = 5;
                default: f0 = {$urandom, $urandom};
            endcase
            b1 = $urandom_range(0, 1) ? {$urandom, $urandom}
                                      : 64'hFFFF_FFFF_FFFF_FFFD;
            case ($urandom_range(0, 4))
                0: l2 = 0;
                1, 2: l2 = DW'($urandom_range(1, 6));
                3: l2 = 64'hFFFF_FFFF_FFFF_FFFF;
                default: l2 = {$urandom, $urandom};
            endcase
            md = $urandom_range(0, 1);
            do_call(s7, f0, b1, l2, md, md == 0);
        end

        do_call(93, 64'hDEAD_BEEF_0000_0042, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
